// File: rtl/ahb2apb_bridge_p.sv
// AHB-Lite slave to APB4 master bridge with a one-hot slave decoder,
// per-slave wait states, error mapping (PSLVERR, bad decode/size, timeout)
// and byte-strobe generation.
//
// Handshakes: an AHB transfer is accepted only when HSEL & HREADY and HTRANS
// is NONSEQ/SEQ while the bridge is IDLE; HREADYOUT low stalls the master's
// data phase. On APB, a transfer completes in the first ACCESS cycle where
// the selected slave's PREADY is high; PREADY/PSLVERR/PRDATA of unselected
// slaves are never looked at.
module ahb2apb_bridge_p #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_LSB    = 12,
  parameter int TIMEOUT    = 256
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    HSEL,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [31:0]             HWDATA,
  input  logic                    HREADY,
  output logic [31:0]             HRDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [31:0]             PWDATA,
  output logic                    PWRITE,
  output logic                    PENABLE,
  output logic [3:0]              PSTRB,
  output logic [NUM_SLAVES-1:0]   PSEL,
  input  logic [NUM_SLAVES*32-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]   PREADY,
  input  logic [NUM_SLAVES-1:0]   PSLVERR
);

  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW:0]   NUM_SL  = (IW+1)'(NUM_SLAVES);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_ERR1   = 3'd3,
    S_ERR2   = 3'd4
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [1:0]            size_q;
  logic [IW-1:0]         idx_q;
  logic [31:0]           pwdata_q;
  logic [31:0]           hrdata_q;
  logic [CW-1:0]         cnt_q;

  logic          trans_valid;
  logic          capture;
  logic [IW-1:0] idx_in;
  logic          bad_req;
  logic          apb_active;
  logic          timeout_hit;
  logic          sel_ready;
  logic          sel_err;
  logic [31:0]   sel_rdata;
  logic [3:0]    strb;

  // Address-phase qualification and decode of the incoming request.
  always_comb begin
    trans_valid = (HTRANS == 2'b10) || (HTRANS == 2'b11);
    capture     = (state == S_IDLE) && HSEL && HREADY && trans_valid;
    idx_in      = HADDR[SEL_LSB +: IW];
    bad_req     = ({1'b0, idx_in} >= NUM_SL) || (HSIZE > 3'd2);
    timeout_hit = (TIMEOUT > 0) && (cnt_q == TO_LAST);
  end

  // Pick the response signals of the currently addressed slave only.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IW'(i)) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[i*32 +: 32];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic and state-decoded AHB/APB control outputs.
  always_comb begin
    state_nx   = state;
    HREADYOUT  = 1'b1;
    HRESP      = 1'b0;
    PENABLE    = 1'b0;
    apb_active = 1'b0;
    case (state)
      S_IDLE: begin
        if (capture) state_nx = bad_req ? S_ERR1 : S_SETUP;
      end
      S_SETUP: begin
        HREADYOUT  = 1'b0;
        apb_active = 1'b1;
        state_nx   = S_ACCESS;
      end
      S_ACCESS: begin
        HREADYOUT  = 1'b0;
        apb_active = 1'b1;
        PENABLE    = 1'b1;
        if (sel_ready)        state_nx = sel_err ? S_ERR1 : S_IDLE;
        else if (timeout_hit) state_nx = S_ERR1;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nx  = S_ERR2;
      end
      S_ERR2: begin
        HRESP    = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Request capture, write-data hold, read-data return and wait counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      idx_q    <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (capture) begin
        addr_q   <= HADDR;
        write_q  <= HWRITE;
        size_q   <= HSIZE[1:0];
        idx_q    <= idx_in;
        hrdata_q <= '0;
      end
      if (state == S_SETUP) pwdata_q <= HWDATA;
      if (state == S_ACCESS && sel_ready && !sel_err)
        hrdata_q <= write_q ? 32'h0 : sel_rdata;
      if (state == S_ACCESS && state_nx == S_ACCESS) cnt_q <= cnt_q + CW'(1);
      else                                            cnt_q <= '0;
    end
  end

  // One-hot select and byte strobes, driven only during SETUP/ACCESS.
  always_comb begin
    PSEL = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      PSEL[i] = apb_active && (idx_q == IW'(i));
    strb = 4'b0000;
    if (write_q) begin
      case (size_q)
        2'd0:    strb = 4'b0001 << addr_q[1:0];
        2'd1:    strb = addr_q[1] ? 4'b1100 : 4'b0011;
        default: strb = 4'b1111;
      endcase
    end
    PSTRB = apb_active ? strb : 4'b0000;
  end

  // Write data is passed through in SETUP so the slave sees it immediately.
  always_comb begin
    PADDR  = addr_q;
    PWRITE = write_q;
    HRDATA = hrdata_q;
    PWDATA = (state == S_SETUP) ? HWDATA : pwdata_q;
  end

endmodule

// File: tb/tb_ahb2apb_bridge_p.sv
// Bench for ahb2apb_bridge_p: randomized AHB transfers against a
// transaction-level reference, plus directed cases on a 3-slave instance.
module tb_ahb2apb_bridge_p;
  localparam int NS = 4;
  localparam int TO = 8;
  localparam int SL = 12;
  localparam int IWA = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  // ---------------- DUT A (4 slaves, timeout 8) ----------------
  logic        hsel, hwrite, hready, hreadyout, hresp, pwrite, penable;
  logic [31:0] haddr, hwdata, hrdata, paddr, pwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [3:0]  pstrb;
  logic [NS-1:0]    psel, pready, pslverr;
  logic [NS*32-1:0] prdata;

  ahb2apb_bridge_p #(.ADDR_WIDTH(32), .NUM_SLAVES(NS), .SEL_LSB(SL), .TIMEOUT(TO)) dut_a (
    .clk(clk), .n_rst(n_rst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HRDATA(hrdata), .HREADYOUT(hreadyout), .HRESP(hresp), .PADDR(paddr),
    .PWDATA(pwdata), .PWRITE(pwrite), .PENABLE(penable), .PSTRB(pstrb),
    .PSEL(psel), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr));

  // ---------------- DUT B (3 slaves, timeout 4) ----------------
  logic        b_hsel, b_hwrite, b_hready, b_hreadyout, b_hresp, b_pwrite, b_penable;
  logic [31:0] b_haddr, b_hwdata, b_hrdata, b_paddr, b_pwdata;
  logic [1:0]  b_htrans;
  logic [2:0]  b_hsize;
  logic [3:0]  b_pstrb;
  logic [2:0]  b_psel, b_pready, b_pslverr;
  logic [95:0] b_prdata;

  ahb2apb_bridge_p #(.ADDR_WIDTH(32), .NUM_SLAVES(3), .SEL_LSB(SL), .TIMEOUT(4)) dut_b (
    .clk(clk), .n_rst(n_rst), .HSEL(b_hsel), .HADDR(b_haddr), .HTRANS(b_htrans),
    .HWRITE(b_hwrite), .HSIZE(b_hsize), .HWDATA(b_hwdata), .HREADY(b_hready),
    .HRDATA(b_hrdata), .HREADYOUT(b_hreadyout), .HRESP(b_hresp), .PADDR(b_paddr),
    .PWDATA(b_pwdata), .PWRITE(b_pwrite), .PENABLE(b_penable), .PSTRB(b_pstrb),
    .PSEL(b_psel), .PRDATA(b_prdata), .PREADY(b_pready), .PSLVERR(b_pslverr));

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic          hro;
    logic          hresp;
    logic          chk_rd;
    logic [31:0]   hrdata;
    logic [NS-1:0] psel;
    logic          pen;
    logic          chk_apb;
    logic [31:0]   paddr;
    logic          pwr;
    logic [3:0]    pstrb;
    logic          chk_wd;
    logic [31:0]   pwdata;
  } exp_t;
  exp_t exp_q[$];

  bit            chk_en = 1'b0;
  int            low_run = 0, last_low_run = 0, psel_cycles = 0;
  bit            err_seen = 1'b0;
  logic [3:0]    setup_pstrb;
  logic [NS-1:0] setup_psel;
  logic [31:0]   setup_paddr, setup_pwdata;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare process: every cycle, DUT A outputs against the reference trace.
  always @(negedge clk) begin
    if (chk_en && n_rst) begin
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("hreadyout", hreadyout, e.hro);
        chk("hresp", hresp, e.hresp);
        chk("psel", psel, e.psel);
        chk("penable", penable, e.pen);
        if (e.chk_rd) chk("hrdata", hrdata, e.hrdata);
        if (e.chk_apb) begin
          chk("paddr", paddr, e.paddr);
          chk("pwrite", pwrite, e.pwr);
          chk("pstrb", pstrb, e.pstrb);
        end
        if (e.chk_wd) chk("pwdata", pwdata, e.pwdata);
      end else begin
        chk("idle_hreadyout", hreadyout, 1'b1);
        chk("idle_hresp", hresp, 1'b0);
        chk("idle_psel", psel, '0);
        chk("idle_penable", penable, 1'b0);
      end
      if (!hreadyout) low_run++;
      else if (low_run > 0) begin last_low_run = low_run; low_run = 0; end
      if (psel != '0) psel_cycles++;
      if (psel != '0 && !penable) begin
        setup_pstrb = pstrb; setup_psel = psel; setup_paddr = paddr; setup_pwdata = pwdata;
      end
      if (hresp) err_seen = 1'b1;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [3:0] model_strb(input logic [31:0] a, input logic [2:0] sz, input logic wr);
    logic [1:0] lo;
    lo = a[1:0];
    if (!wr) return 4'b0000;
    case (sz)
      3'd0:    return 4'(1 << lo);
      3'd1:    return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Expected per-cycle trace of one transfer, starting at its first data-phase cycle.
  task automatic push_model(input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                            input logic [31:0] wdata, input int waits, input bit err,
                            input logic [31:0] rdata, output int n, output int nacc,
                            output bit is_err, output int idx);
    exp_t base, e;
    idx = int'((addr >> SL) & ((1 << IWA) - 1));
    base = '0;
    if (idx >= NS || sz > 3'd2) begin
      nacc = 0; is_err = 1'b1;
    end else begin
      base.psel    = NS'(1 << idx);
      base.chk_apb = 1'b1;
      base.paddr   = addr;
      base.pwr     = wr;
      base.pstrb   = model_strb(addr, sz, wr);
      base.chk_wd  = wr;
      base.pwdata  = wdata;
      exp_q.push_back(base);
      nacc = (waits >= TO) ? TO : waits + 1;
      e = base; e.pen = 1'b1;
      for (int k = 0; k < nacc; k++) exp_q.push_back(e);
      is_err = (waits >= TO) || err;
    end
    if (is_err) begin
      e = '0; e.hresp = 1'b1;
      exp_q.push_back(e);
      e.hro = 1'b1; e.chk_rd = 1'b1; e.hrdata = 32'h0;
      exp_q.push_back(e);
    end else begin
      e = '0; e.hro = 1'b1; e.chk_rd = 1'b1; e.hrdata = wr ? 32'h0 : rdata;
      exp_q.push_back(e);
    end
    n = (nacc > 0 ? 1 + nacc : 0) + (is_err ? 2 : 1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic noise_slaves();
    pready  = NS'($urandom);
    pslverr = NS'($urandom);
    prdata  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Called at the start of a cycle in which the bridge is ready to accept.
  task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                         input logic [31:0] wdata, input int waits, input bit err,
                         input logic [31:0] rdata);
    int n, nacc, idx;
    bit is_err;
    hsel = 1'b1; hready = 1'b1; htrans = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
    haddr = addr; hwrite = wr; hsize = sz; hwdata = $urandom;
    @(posedge clk); #1;
    htrans = 2'b00; hsel = 1'($urandom); haddr = $urandom; hwrite = 1'($urandom);
    hsize = 3'($urandom_range(0, 7)); hwdata = wdata;
    push_model(addr, wr, sz, wdata, waits, err, rdata, n, nacc, is_err, idx);
    for (int c = 0; c < n; c++) begin
      noise_slaves();
      if (c > 0) hwdata = $urandom;
      if (c >= 1 && c <= nacc) begin
        pready[idx]  = (c - 1 >= waits);
        pslverr[idx] = err;
        prdata[idx*32 +: 32] = rdata;
      end
      if (is_err && c == n - 1) begin
        hsel = 1'b1; hready = 1'b1; htrans = 2'b10; haddr = $urandom;
      end
      if (c < n - 1) begin @(posedge clk); #1; end
    end
    if (is_err) begin
      @(posedge clk); #1;
      htrans = 2'b00; hsel = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      case ($urandom_range(0, 2))
        0: begin hsel = 1'b0; htrans = 2'b10; hready = 1'b1; end
        1: begin hsel = 1'b1; htrans = 2'($urandom_range(0, 1)); hready = 1'b1; end
        default: begin hsel = 1'b1; htrans = 2'b10; hready = 1'b0; end
      endcase
      haddr = $urandom; hwrite = 1'($urandom); hsize = 3'($urandom_range(0, 7));
      noise_slaves();
      @(posedge clk); #1;
    end
    hsel = 1'b0; htrans = 2'b00; hready = 1'b1;
  endtask

  task automatic clear_trk();
    psel_cycles = 0; err_seen = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    n_rst = 1'b0;
    hsel = 0; haddr = 0; htrans = 0; hwrite = 0; hsize = 0; hwdata = 0; hready = 1;
    pready = 0; pslverr = 0; prdata = '0;
    b_hsel = 0; b_haddr = 0; b_htrans = 0; b_hwrite = 0; b_hsize = 0; b_hwdata = 0; b_hready = 1;
    b_pready = 0; b_pslverr = 0; b_prdata = '0;
    #12;
    chk("rst_hreadyout", hreadyout, 1'b1);
    chk("rst_hresp", hresp, 1'b0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_psel", psel, 4'b0000);
    chk("rst_penable", penable, 1'b0);
    chk("rst_pwrite", pwrite, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_pstrb", pstrb, 4'h0);
    #3 n_rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    idle_cycles(3);

    // Zero-wait word write to slave 1.
    clear_trk();
    do_xfer(32'h0000_1004, 1'b1, 3'd2, 32'hDEADBEEF, 0, 1'b0, 32'h0);
    @(negedge clk); #1;
    chk("wr_low_cycles", 32'(last_low_run), 32'd2);
    chk("wr_psel_cycles", 32'(psel_cycles), 32'd2);
    chk("wr_psel", setup_psel, 4'b0010);
    chk("wr_paddr", setup_paddr, 32'h0000_1004);
    chk("wr_pwdata", setup_pwdata, 32'hDEADBEEF);
    chk("wr_pstrb", setup_pstrb, 4'hF);
    chk("wr_hresp", hresp, 1'b0);
    idle_cycles(1);

    // Read from slave 3 with three wait states.
    clear_trk();
    do_xfer(32'h0000_3000, 1'b0, 3'd2, 32'h0, 3, 1'b0, 32'h12345678);
    @(negedge clk); #1;
    chk("rd_low_cycles", 32'(last_low_run), 32'd5);
    chk("rd_hrdata", hrdata, 32'h12345678);
    chk("rd_hresp", hresp, 1'b0);
    chk("rd_psel", setup_psel, 4'b1000);
    idle_cycles(1);

    // Byte and half-word strobes, then an illegal size.
    do_xfer(32'h0000_2002, 1'b1, 3'd0, 32'hA5A5A5A5, 0, 1'b0, 32'h0);
    @(negedge clk); #1;
    chk("byte_pstrb", setup_pstrb, 4'b0100);
    idle_cycles(1);
    do_xfer(32'h0000_2002, 1'b1, 3'd1, 32'h5A5A5A5A, 1, 1'b0, 32'h0);
    @(negedge clk); #1;
    chk("half_pstrb", setup_pstrb, 4'b1100);
    idle_cycles(1);
    clear_trk();
    do_xfer(32'h0000_2000, 1'b1, 3'd3, 32'h1, 0, 1'b0, 32'h0);
    @(negedge clk); #1;
    chk("size3_psel_cycles", 32'(psel_cycles), 32'd0);
    chk("size3_err", err_seen, 1'b1);
    chk("size3_low_cycles", 32'(last_low_run), 32'd1);
    idle_cycles(1);

    // Slave error from slave 0.
    clear_trk();
    do_xfer(32'h0000_0010, 1'b0, 3'd2, 32'h0, 0, 1'b1, 32'hFFFF0000);
    @(negedge clk); #1;
    chk("slverr_err", err_seen, 1'b1);
    chk("slverr_low_cycles", 32'(last_low_run), 32'd3);
    chk("slverr_psel_cycles", 32'(psel_cycles), 32'd2);
    idle_cycles(1);

    // Timeout on the 8-cycle instance.
    clear_trk();
    do_xfer(32'h0000_2010, 1'b1, 3'd2, 32'h77, 20, 1'b0, 32'h0);
    @(negedge clk); #1;
    chk("to_psel_cycles", 32'(psel_cycles), 32'(1 + TO));
    chk("to_err", err_seen, 1'b1);
    idle_cycles(1);

    // Randomized traffic, back-to-back or with gaps.
    for (int t = 0; t < 150; t++) begin
      logic [31:0] a;
      logic [2:0]  sz;
      int          w;
      a  = $urandom;
      sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      w  = ($urandom_range(0, 5) == 0) ? $urandom_range(4, 11) : $urandom_range(0, 3);
      do_xfer(a, 1'($urandom), sz, $urandom, w, ($urandom_range(0, 4) == 0), $urandom);
      if ($urandom_range(0, 1) != 0) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(2);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset asserted in ACCESS aborts the transfer asynchronously.
    chk_en = 1'b0;
    hsel = 1'b1; hready = 1'b1; htrans = 2'b10; haddr = 32'h0000_2000; hwrite = 1'b0; hsize = 3'd2;
    pready = '0;
    @(posedge clk); #1;
    htrans = 2'b00; hsel = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstmid_penable_before", penable, 1'b1);
    chk("rstmid_psel_before", psel, 4'b0100);
    n_rst = 1'b0;
    #1;
    chk("rstmid_psel", psel, 4'b0000);
    chk("rstmid_penable", penable, 1'b0);
    chk("rstmid_hreadyout", hreadyout, 1'b1);
    chk("rstmid_hresp", hresp, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;
    exp_q.delete();
    low_run = 0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    clear_trk();
    do_xfer(32'h0000_1008, 1'b1, 3'd2, 32'hCAFEF00D, 1, 1'b0, 32'h0);
    @(negedge clk); #1;
    chk("post_rst_pwdata", setup_pwdata, 32'hCAFEF00D);
    chk("post_rst_hresp", hresp, 1'b0);
    chk("post_rst_low_cycles", 32'(last_low_run), 32'd3);
    idle_cycles(2);

    // 3-slave instance: decode error at 0x3000.
    b_hsel = 1'b1; b_htrans = 2'b10; b_haddr = 32'h0000_3000; b_hwrite = 1'b0; b_hsize = 3'd2;
    @(posedge clk); #1;
    b_htrans = 2'b00; b_hsel = 1'b0;
    @(negedge clk);
    chk("b_dec_err1_hro", b_hreadyout, 1'b0);
    chk("b_dec_err1_hresp", b_hresp, 1'b1);
    chk("b_dec_err1_psel", b_psel, 3'b000);
    @(negedge clk);
    chk("b_dec_err2_hro", b_hreadyout, 1'b1);
    chk("b_dec_err2_hresp", b_hresp, 1'b1);
    chk("b_dec_err2_psel", b_psel, 3'b000);
    @(negedge clk);
    chk("b_dec_idle_hresp", b_hresp, 1'b0);
    @(posedge clk); #1;

    // 3-slave instance: timeout after 4 ACCESS cycles.
    b_pready = 3'b000;
    b_hsel = 1'b1; b_htrans = 2'b10; b_haddr = 32'h0000_1000; b_hwrite = 1'b1; b_hsize = 3'd2;
    b_hwdata = 32'h0;
    @(posedge clk); #1;
    b_htrans = 2'b00; b_hsel = 1'b0; b_hwdata = 32'h0BADC0DE;
    @(negedge clk);
    chk("b_to_setup_psel", b_psel, 3'b010);
    chk("b_to_setup_pen", b_penable, 1'b0);
    chk("b_to_setup_pwdata", b_pwdata, 32'h0BADC0DE);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("b_to_access_psel", b_psel, 3'b010);
      chk("b_to_access_pen", b_penable, 1'b1);
      chk("b_to_access_hro", b_hreadyout, 1'b0);
    end
    @(negedge clk);
    chk("b_to_err1_psel", b_psel, 3'b000);
    chk("b_to_err1_hro", b_hreadyout, 1'b0);
    chk("b_to_err1_hresp", b_hresp, 1'b1);
    @(negedge clk);
    chk("b_to_err2_hro", b_hreadyout, 1'b1);
    chk("b_to_err2_hresp", b_hresp, 1'b1);
    @(posedge clk); #1;
    idle_cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb2apb_bridge_p.md
Name: ahb2apb_bridge_p

Overview:
- Parametrised AHB-Lite slave to APB4 master bridge with an integrated one-hot slave decoder, per-slave PREADY wait states, PSLVERR/decode/timeout to AHB ERROR mapping, and PSTRB generation.
- Sits behind the AHB-Lite interconnect as a single AHB slave and fans out to NUM_SLAVES APB peripherals.
- Successor to the fixed two-slave, zero-wait APB bridge.

Parameters:
- ADDR_WIDTH, 32, width of HADDR and PADDR.
- NUM_SLAVES, 4, number of APB slaves (1..16).
- SEL_LSB, 12, LSB of the slave-index field in HADDR. Index field is IW = max(1, clog2(NUM_SLAVES)) bits wide.
- TIMEOUT, 256, maximum ACCESS cycles with PREADY low before an error is returned. 0 disables the timeout.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- HSEL  in  1  AHB slave select
- HADDR  in  ADDR_WIDTH  AHB address
- HTRANS  in  2  AHB transfer type
- HWRITE  in  1  AHB write
- HSIZE  in  3  AHB transfer size
- HWDATA  in  32  AHB write data
- HREADY  in  1  AHB bus ready (previous transfer complete)
- HRDATA  out  32  AHB read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB write
- PENABLE  out  1  APB enable
- PSTRB  out  4  APB byte strobes
- PSEL  out  NUM_SLAVES  one-hot APB select
- PRDATA  in  NUM_SLAVES*32  flattened slave read data; slave i occupies bits [32i+31:32i]
- PREADY  in  NUM_SLAVES  per-slave ready
- PSLVERR  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset (async, n_rst low): state=IDLE. HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, timeout counter=0. Reset mid-transfer aborts immediately; there is no APB completion.
- Capture: in IDLE, HSEL & HREADY & HTRANS[1] registers HADDR, HWRITE, HSIZE, and the slave index HADDR[SEL_LSB +: IW].
- Zero-wait OKAY: IDLE or BUSY HTRANS, or HSEL low, gives an OKAY response with HREADYOUT held at 1.
- Error at capture: index >= NUM_SLAVES, or HSIZE > 2, goes to ERR1. No PSEL is asserted.
- States are IDLE, SETUP, ACCESS, ERR1, ERR2, all registered.
- SETUP: PSEL[idx]=1, PENABLE=0, HREADYOUT=0.
  - PSTRB: writes use byte=1<<HADDR[1:0], half=HADDR[1]?4'b1100:4'b0011, word=4'b1111. Reads use 4'b0000.
  - PWDATA=HWDATA combinationally in this cycle and is registered at its end.
  - Always -> ACCESS.
- ACCESS: PSEL held, PENABLE=1, PWDATA from register. PADDR, PWRITE and PSTRB are stable from SETUP.
  - PREADY[idx]=0: stay in ACCESS and increment the counter.
  - PREADY[idx]=1 & PSLVERR[idx]=0: -> IDLE. Next cycle HREADYOUT=1, HRESP=0, HRDATA=PRDATA slice idx (reads) or 0 (writes).
  - PREADY[idx]=1 & PSLVERR[idx]=1: -> ERR1.
  - Counter reaches TIMEOUT (TIMEOUT>0) with PREADY low: -> ERR1.
  - On any exit from ACCESS, PSEL and PENABLE drop; the counter clears.
- ERR1: HREADYOUT=0, HRESP=1. -> ERR2.
- ERR2: HREADYOUT=1, HRESP=1, HRDATA=0. -> IDLE. A transfer presented in ERR2 is ignored; the master must cancel it per AHB.
- Latency: zero-wait APB read or write gives 3 AHB data-phase cycles (SETUP, ACCESS, done). Each PREADY-low cycle adds one.
- PSEL is never multi-hot. PRDATA, PREADY and PSLVERR of unselected slaves are ignored.
- HREADYOUT=1 only in IDLE/done and ERR2. New captures occur only in IDLE.

Test Plan:
- Write HADDR=0x0000_1004, HSIZE=2, HWDATA=0xDEADBEEF, slave1 PREADY=1 -> PSEL=4'b0010 for 2 cycles; PADDR=0x1004, PWDATA=0xDEADBEEF, PSTRB=4'hF; PENABLE on cycle 2; HREADYOUT low 2 cycles then OKAY.
- Read 0x0000_3000 with slave3 PREADY low for 3 ACCESS cycles, PRDATA=0x12345678 -> HREADYOUT low 5 cycles; then HRDATA=0x12345678, HRESP=0.
- Byte write HADDR=0x2002 -> PSTRB=4'b0100. Half write HADDR=0x2002 -> PSTRB=4'b1100. HSIZE=3 -> ERROR with no PSEL.
- Slave0 returns PSLVERR=1 with PREADY=1 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1).
- With NUM_SLAVES=3, access 0x3000 -> immediate 2-cycle ERROR and PSEL stays 0. With TIMEOUT=4 and PREADY stuck low -> PSEL drops after 4 ACCESS cycles, then ERROR.
- Assert n_rst low in ACCESS -> PSEL=0, PENABLE=0, HREADYOUT=1 asynchronously. After release, a new OKAY transfer completes normally.
